hello_scroll_gen: RTL and testbench
===================================

Name: hello_scroll_gen

Overview:
- Sequential producer of the 15-bit character-code bus (five 3-bit codes) that drives the HEX4..HEX0 character decoders.
- Replaces manual switch-selected rotation with timed automatic scrolling of a loadable 5-character message.
- Character codes: 000=H, 001=E, 010=L, 011=O, 1xx=blank.
- Sits between the board switches/keys and the five per-digit character decoders in the top level.

Parameters:
- TICK_DIV, 25000000, clock cycles per scroll step (0.5 s at 50 MHz); legal range >= 2.
- CNT_W, 25, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- Clock  input  1  system clock; all state on rising edge.
- Reset  input  1  reset, asynchronous and active-high.
- Load  input  1  load strobe; samples Din for one cycle.
- Din  input  15  message codes; Din[14:12]=leftmost char (HEX4), Din[2:0]=rightmost (HEX0).
- Run  input  1  1 = scrolling enabled, 0 = paused.
- Dir  input  1  0 = scroll left, 1 = scroll right.
- M  output  15  current code bus; M[14:12] to HEX4 … M[2:0] to HEX0.
- Pos  output  3  current rotation index, 0..4.
- Tick  output  1  one-cycle pulse on each scroll step.

Behaviour:
- Registers: msg[14:0], pos[2:0], cnt[CNT_W-1:0], blank_ph (BLINK_EN only).
- Reset (async, immediate):
  - msg = 15'b000_001_010_010_011 ("HELLO").
  - pos = 0, cnt = 0, Tick = 0, blank_ph = 0.
  - M = 15'b000_001_010_010_011.
- M is combinational from msg and pos:
  - M = msg rotated left by 3*pos bits; characters wrap.
  - pos=1 with HELLO gives E,L,L,O,H.
  - pos values 5..7 are unreachable; if present, M = msg.
- Output latency: M changes in the cycle after the edge that updates msg or pos.
- Prescaler:
  - When Run=1: cnt increments each cycle.
  - When cnt == TICK_DIV-1: cnt <= 0 and a step occurs.
  - Tick is registered and is high for the one cycle following the step edge.
  - When Run=0: cnt holds its value and no steps occur (see BLINK_EN for the exception).
- Step:
  - Dir=0: pos <= (pos==4) ? 0 : pos+1.
  - Dir=1: pos <= (pos==0) ? 4 : pos-1.
  - Dir is sampled at the step edge only; mid-period changes take effect at the next step.
- Load (priority over step in the same cycle):
  - msg <= Din, pos <= 0, cnt <= 0, blank_ph <= 0.
  - No Tick in that cycle.
  - Load held high keeps reloading every cycle and blocks scrolling.
- Run 0->1 resumes from the held cnt; a partial period is not restarted.
- Reset asserted mid-period returns all state to reset values immediately. Scrolling resumes TICK_DIV cycles after deassertion if Run=1.
- Din codes 1xx pass through unchanged (blank digits).

Optional Feature:
- Macro: HELLO_SCROLL_BLINK_EN.
- Defined:
  - While Run=0, cnt free-runs with the same TICK_DIV period.
  - Each wrap toggles blank_ph and pulses Tick; pos does not change.
  - While blank_ph=1, M = 15'h7FFF (all blank).
  - blank_ph clears on Run=1, Load, or Reset.
  - On Run 0->1, cnt is zeroed.
- Undefined:
  - No blank_ph register.
  - Paused output is static M; cnt holds as described in Behaviour.

Test Plan (TICK_DIV=4):
1. Reset pulse with Run=0 -> M=15'b000_001_010_010_011, Pos=0, Tick=0, held for 20 cycles (no macro).
2. Run=1, Dir=0 from reset -> Tick every 4th cycle; Pos sequence 1,2,3,4,0. At Pos=1, M=15'b001_010_010_011_000.
3. Run=1, Dir=1 from reset -> first step gives Pos=4, M=15'b011_000_001_010_010.
4. Load=1 with Din=15'b011_011_111_111_111 in the same cycle as a step -> Pos=0, M=Din, no Tick that cycle; next step occurs 4 cycles later.
5. Run=1 for 6 cycles, Run=0 for 10 cycles, Run=1 -> Pos=1 throughout the pause; next Tick 2 cycles after resume.
6. With HELLO_SCROLL_BLINK_EN, Run=0 -> M alternates HELLO / 15'h7FFF every 4 cycles with Pos=0; Run=1 -> M=HELLO immediately and scrolling proceeds.

Source files
------------

// File: rtl/hello_scroll_gen_if.sv
// Bundle between the switch/key logic and hello_scroll_gen: message load,
// scroll control, and the five-character code bus feeding HEX4..HEX0.
interface hello_scroll_gen_if;
  logic        load;
  logic [14:0] din;
  logic        run;
  logic        dir;
  logic [14:0] m;
  logic [2:0]  pos;
  logic        tick;

  modport master (output load, output din, output run, output dir,
                  input  m,    input  pos, input  tick);
  modport slave  (input  load, input  din, input  run, input  dir,
                  output m,    output pos, output tick);
endinterface

// File: rtl/hello_scroll_gen.sv
// Timed scroller for a loadable 5-character message on HEX4..HEX0.
// Optional macro HELLO_SCROLL_BLINK_EN: blink the whole display while paused.
module hello_scroll_gen #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic              clk,
  input  logic              rst,
  hello_scroll_gen_if.slave bus
);

  localparam int unsigned MSG_W = 15;
  localparam int unsigned POS_W = 3;
  localparam logic [MSG_W-1:0] HELLO    = 15'b000_001_010_010_011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = 3'd4;

  logic [MSG_W-1:0] msg,  msg_n;
  logic [POS_W-1:0] pos_q, pos_n;
  logic [CNT_W-1:0] cnt,  cnt_n;
  logic             tick_q, tick_n;
  logic             wrap_c;
  logic [MSG_W-1:0] rot_c;
`ifdef HELLO_SCROLL_BLINK_EN
  logic             blank_ph, blank_n;
  logic             run_q;
`endif

  assign wrap_c = (cnt == CNT_LAST);

  // Next-state: load beats step; steps only on prescaler wrap
  always_comb begin
    msg_n  = msg;
    pos_n  = pos_q;
    cnt_n  = cnt;
    tick_n = 1'b0;
`ifdef HELLO_SCROLL_BLINK_EN
    blank_n = blank_ph;
`endif
    if (bus.load) begin
      msg_n = bus.din;
      pos_n = '0;
      cnt_n = '0;
`ifdef HELLO_SCROLL_BLINK_EN
      blank_n = 1'b0;
`endif
    end else if (bus.run) begin
`ifdef HELLO_SCROLL_BLINK_EN
      blank_n = 1'b0;
`endif
      if (wrap_c) begin
        cnt_n  = '0;
        tick_n = 1'b1;
        if (bus.dir) pos_n = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        else         pos_n = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
`ifdef HELLO_SCROLL_BLINK_EN
      // Resuming from a blink pause starts a fresh scroll period
      if (!run_q) begin
        cnt_n  = '0;
        tick_n = 1'b0;
        pos_n  = pos_q;
      end
    end else begin
      if (wrap_c) begin
        cnt_n   = '0;
        tick_n  = 1'b1;
        blank_n = ~blank_ph;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg    <= HELLO;
      pos_q  <= '0;
      cnt    <= '0;
      tick_q <= 1'b0;
`ifdef HELLO_SCROLL_BLINK_EN
      blank_ph <= 1'b0;
      run_q    <= 1'b0;
`endif
    end else begin
      msg    <= msg_n;
      pos_q  <= pos_n;
      cnt    <= cnt_n;
      tick_q <= tick_n;
`ifdef HELLO_SCROLL_BLINK_EN
      blank_ph <= blank_n;
      run_q    <= bus.run;
`endif
    end
  end

  // Rotate left by whole characters; unreachable indices show the raw message
  always_comb begin
    case (pos_q)
      3'd1:    rot_c = {msg[11:0], msg[14:12]};
      3'd2:    rot_c = {msg[8:0],  msg[14:9]};
      3'd3:    rot_c = {msg[5:0],  msg[14:6]};
      3'd4:    rot_c = {msg[2:0],  msg[14:3]};
      default: rot_c = msg;
    endcase
  end

`ifdef HELLO_SCROLL_BLINK_EN
  assign bus.m = (blank_ph && !bus.run) ? 15'h7FFF : rot_c;
`else
  assign bus.m = rot_c;
`endif
  assign bus.pos  = pos_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_hello_scroll_gen.sv
// Directed bench for hello_scroll_gen (TICK_DIV=4) with a character-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_hello_scroll_gen;

  localparam int unsigned TD = 4;
  localparam logic [14:0] HELLO = 15'b000_001_010_010_011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  hello_scroll_gen_if bus();

  hello_scroll_gen #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: message as five characters, a display index and a period count
  logic [2:0] chars [5];
  int         mpos;
  int         elapsed;
  logic       mtick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      chars[0] <= 3'd0; chars[1] <= 3'd1; chars[2] <= 3'd2;
      chars[3] <= 3'd2; chars[4] <= 3'd3;
      mpos    <= 0;
      elapsed <= 0;
      mtick   <= 1'b0;
    end else if (bus.load) begin
      for (int i = 0; i < 5; i++) chars[i] <= bus.din[14 - 3*i -: 3];
      mpos    <= 0;
      elapsed <= 0;
      mtick   <= 1'b0;
    end else if (bus.run && (elapsed + 1 == TD)) begin
      elapsed <= 0;
      mtick   <= 1'b1;
      mpos    <= bus.dir ? (mpos + 4) % 5 : (mpos + 1) % 5;
    end else begin
      elapsed <= bus.run ? elapsed + 1 : elapsed;
      mtick   <= 1'b0;
    end
  end

  function automatic logic [14:0] model_m();
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[14 - 3*i -: 3] = chars[(i + mpos) % 5];
    return r;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if (bus.m !== model_m() || bus.pos !== 3'(mpos) || bus.tick !== mtick) begin
        n_fail++;
        $display("FAIL model t=%0t m=%b/%b pos=%0d/%0d tick=%b/%b", $time,
                 bus.m, model_m(), bus.pos, mpos, bus.tick, mtick);
      end
    end
  end

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.load = 1'b0; bus.dir = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  int exp_seq [5] = '{1, 2, 3, 4, 0};

  initial begin
    bus.load = 1'b0; bus.din = '0; bus.run = 1'b0; bus.dir = 1'b0;
    cyc(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_m", bus.m, HELLO);
    chk("rst_pos", 15'(bus.pos), 15'd0);
    chk("rst_tick", 15'(bus.tick), 15'd0);
    cyc(20);
    chk("idle_m", bus.m, HELLO);
    chk("idle_pos", 15'(bus.pos), 15'd0);

    // Left scroll: tick on every 4th edge, pos 1,2,3,4,0
    do_reset();
    bus.run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(TD - 1);
      chk("left_notick", 15'(bus.tick), 15'd0);
      cyc(1);
      chk("left_tick", 15'(bus.tick), 15'd1);
      chk("left_pos", 15'(bus.pos), 15'(exp_seq[k]));
      if (k == 0) chk("left_m1", bus.m, 15'b001_010_010_011_000);
    end

    // Right scroll: first step wraps to 4
    do_reset();
    bus.run = 1'b1; bus.dir = 1'b1;
    cyc(TD);
    chk("right_pos", 15'(bus.pos), 15'd4);
    chk("right_m", bus.m, 15'b011_000_001_010_010);

    // Load coinciding with a step edge
    do_reset();
    bus.run = 1'b1;
    cyc(TD - 1);
    bus.load = 1'b1; bus.din = 15'b011_011_111_111_111;
    cyc(1);
    bus.load = 1'b0;
    chk("load_pos", 15'(bus.pos), 15'd0);
    chk("load_m", bus.m, 15'b011_011_111_111_111);
    chk("load_notick", 15'(bus.tick), 15'd0);
    cyc(TD - 1);
    chk("load_wait", 15'(bus.tick), 15'd0);
    cyc(1);
    chk("load_step", 15'(bus.tick), 15'd1);
    chk("load_pos1", 15'(bus.pos), 15'd1);
    chk("load_m1", bus.m, 15'b011_111_111_111_011);

    // Held load blocks scrolling
    bus.load = 1'b1;
    cyc(2 * TD);
    chk("hold_pos", 15'(bus.pos), 15'd0);
    bus.load = 1'b0; bus.dir = 1'b1;
    cyc(TD);
    chk("blank_r_m", bus.m, 15'b111_011_011_111_111);

    // Pause keeps the partial period
    do_reset();
    bus.run = 1'b1;
    cyc(6);
    chk("pause_pos", 15'(bus.pos), 15'd1);
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("pause_hold", 15'(bus.pos), 15'd1);
    end
    bus.run = 1'b1;
    cyc(1);
    chk("resume_notick", 15'(bus.tick), 15'd0);
    cyc(1);
    chk("resume_tick", 15'(bus.tick), 15'd1);
    chk("resume_pos", 15'(bus.pos), 15'd2);

    // Reset mid-period is immediate, then a full period elapses
    cyc(2);
    rst = 1'b1;
    #1;
    chk("midrst_pos", 15'(bus.pos), 15'd0);
    chk("midrst_m", bus.m, HELLO);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(TD - 1);
    chk("post_rst_wait", 15'(bus.tick), 15'd0);
    cyc(1);
    chk("post_rst_step", 15'(bus.pos), 15'd1);

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
